stream_upsize_fifo: RTL

STREAM_UPSIZE_FIFO -- requirements
Module: stream_upsize_fifo

---
 rtl/upsz_pkg.sv | 33 +++
 rtl/stream_upsize_fifo_if.sv | 31 +++
 rtl/upsz_packer.sv | 94 +++++++++
 rtl/stream_upsize_fifo.sv | 106 ++++++++++
 4 files changed

// File: rtl/upsz_pkg.sv
// Shared helpers for the stream upsizing FIFO: width ratio, clog2 and the
// pointer/level width constants derived from the storage depth.
package upsz_pkg;

   localparam int MIN_RATIO = 2;

   function automatic int ratio(input int in_w, input int out_w);
      return out_w / in_w;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Pointer width addresses DEPTH words; level needs one extra bit to hold DEPTH.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

   function automatic int lvl_w(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stream_upsize_fifo_if.sv
// Stream bundle for the upsizing FIFO: narrow input beats and wide output words.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface stream_upsize_fifo_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 256
);
   logic [IN_W-1:0]  s_data;
   logic             s_valid;
   logic             s_ready;
   logic [OUT_W-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready,
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport master (
      output s_data,
      output s_valid,
      input  s_ready,
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/upsz_packer.sv
// Packs R narrow beats into one wide word, first beat in the LSB lane.
// With UPSZ_FLUSH_EN defined, a flush input pushes a zero-padded partial word.
module upsz_packer
   import upsz_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 256,
   localparam int R     = ratio(IN_W, OUT_W),
   localparam int CNT_W = clog2(R)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef UPSZ_FLUSH_EN
   input  logic             flush,
`endif
   input  logic [IN_W-1:0]  s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             full,
   output logic             wr_en,
   output logic [OUT_W-1:0] wr_data,
   output logic [CNT_W-1:0] pcnt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

   logic [OUT_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [OUT_W-1:0] word_c;
   logic             acc;
   logic             last_beat;

`ifdef UPSZ_FLUSH_EN
   logic pend_q, pend_d;
   logic flush_go;

   // A pending flush blocks new beats so the partial word cannot grow past the flush point.
   assign s_ready = !pend_q && ((pcnt_q != LAST) || !full);
`else
   assign s_ready = (pcnt_q != LAST) || !full;
`endif

   assign acc       = s_valid && s_ready;
   assign last_beat = acc && (pcnt_q == LAST);
   assign wr_data   = word_c;
   assign pcnt      = pcnt_q;

   always_comb begin
      word_c = shift_q;
      for (int i = 0; i < R; i++) begin
         if (acc && (pcnt_q == CNT_W'(i))) word_c[i*IN_W +: IN_W] = s_data;
      end
   end

`ifdef UPSZ_FLUSH_EN
   always_comb begin
      // Flush covers the partial word plus any beat accepted this cycle; a completing beat pushes anyway.
      flush_go = (flush || pend_q) && !last_beat && ((pcnt_q != '0) || acc);
      wr_en    = last_beat || (flush_go && !full);
      pend_d   = flush_go && full;
   end
`else
   assign wr_en = last_beat;
`endif

   always_comb begin
      pcnt_d  = pcnt_q;
      shift_d = word_c;
      if (wr_en) begin
         pcnt_d  = '0;
         shift_d = '0;
      end else if (acc) begin
         pcnt_d = pcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         pcnt_q  <= '0;
      end else begin
         shift_q <= shift_d;
         pcnt_q  <= pcnt_d;
      end
   end

`ifdef UPSZ_FLUSH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= 1'b0;
      else     pend_q <= pend_d;
   end
`endif

endmodule

// File: rtl/stream_upsize_fifo.sv
// Width-upsizing first-word-fall-through FIFO: IN_W beats packed into OUT_W words.
// Define UPSZ_FLUSH_EN to add a flush input that pushes a zero-padded partial word.
module stream_upsize_fifo
   import upsz_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 256,
   parameter int DEPTH = 64,
   parameter int AF_TH = DEPTH - 4,
   parameter int AE_TH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef UPSZ_FLUSH_EN
   input  logic                     flush,
`endif
   stream_upsize_fifo_if.slave      bus,
   output logic [lvl_w(DEPTH)-1:0]  level,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty
);

   localparam int R     = ratio(IN_W, OUT_W);
   localparam int CNT_W = clog2(R);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int LVL_W = lvl_w(DEPTH);
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_TH);
   localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_TH);

   if ((OUT_W % IN_W) != 0 || R < MIN_RATIO || !is_pow2(R) || !is_pow2(DEPTH)) begin : g_param_err
      $error("stream_upsize_fifo: OUT_W/IN_W must be a power of 2 >= 2 and DEPTH a power of 2");
   end

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push;
   logic             pop;
   logic [OUT_W-1:0] wr_data;
   logic [CNT_W-1:0] pcnt;

   upsz_packer #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_packer (
      .clk     (clk),
      .rst     (rst),
`ifdef UPSZ_FLUSH_EN
      .flush   (flush),
`endif
      .s_data  (bus.s_data),
      .s_valid (bus.s_valid),
      .s_ready (bus.s_ready),
      .full    (full),
      .wr_en   (push),
      .wr_data (wr_data),
      .pcnt    (pcnt)
   );

   // The packer only raises push when storage has room, so no extra gating here.
   assign pop = !empty && bus.m_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   // Flags decode only the registered level, keeping inputs off the flag paths.
   assign level        = level_q;
   assign full         = (level_q == DEPTH_L);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= AF_L);
   assign almost_empty = (level_q <= AE_L);

   assign bus.m_valid  = !empty;
   assign bus.m_data   = mem[rd_ptr_q];

endmodule
